// File: rtl/mult_eval_engine_pkg.sv
// Shared types and constants for the multiplier evaluation engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_eval_engine_pkg;

  // Run-control states; the encoding is visible on waveforms, so keep it fixed
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Seed used when the caller supplies zero (an all-zero LFSR would lock up)
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Feedback taps for x^16+x^14+x^13+x^11+1 in a left-shifting register
  localparam int LFSR_TAP_0 = 15;
  localparam int LFSR_TAP_1 = 13;
  localparam int LFSR_TAP_2 = 12;
  localparam int LFSR_TAP_3 = 10;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[LFSR_TAP_0] ^ cur[LFSR_TAP_1] ^ cur[LFSR_TAP_2] ^ cur[LFSR_TAP_3]};
  endfunction

endpackage

// File: rtl/mult_eval_engine_if.sv
// Bundle between the evaluation engine and its controller / multiplier under test.
// Latency: n/a (wires only).
// Backpressure: none; start is a level sampled by the engine when idle.
interface mult_eval_engine_if #(
  parameter int WIDTH = 2,
  parameter int ERR_W = 16
);
  logic               start;
  logic [15:0]        seed;
  logic [WIDTH-1:0]   dut_a;
  logic [WIDTH-1:0]   dut_b;
  logic [2*WIDTH-1:0] dut_p;
  logic               busy;
  logic               done;
  logic [15:0]        vec_count;
  logic [ERR_W-1:0]   err_count;
  logic [ERR_W-1:0]   abs_err_sum;
  logic [2*WIDTH-1:0] max_abs_err;

  // Controller side: issues start/seed and hosts the multiplier that returns dut_p
  modport master (
    output start, seed, dut_p,
    input  dut_a, dut_b, busy, done, vec_count, err_count, abs_err_sum, max_abs_err
  );

  // Engine side
  modport slave (
    input  start, seed, dut_p,
    output dut_a, dut_b, busy, done, vec_count, err_count, abs_err_sum, max_abs_err
  );
endinterface

// File: rtl/mult_eval_engine_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) producing operand bits.
// Latency: q reflects a load or advance one cycle after the request.
// Backpressure: none; load has priority over adv, state holds otherwise.
module lfsr16
  import mult_eval_engine_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] r_state;

  // Return to the default seed on reset, otherwise load or step when asked
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= load_val;
    end else if (adv) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign q = r_state;

endmodule

// File: rtl/mult_eval_engine.sv
// Drives LFSR operand pairs into a combinational multiplier and scores its products.
// Latency: 2 cycles per vector; done pulses 2*NUM_VECTORS edges after start is taken.
// Backpressure: none; start is ignored while busy or in DONE and is never queued.
module mult_eval_engine
  import mult_eval_engine_pkg::*;
#(
  parameter int          WIDTH       = 2,
  parameter int          NUM_VECTORS = 20,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_SEED,
  parameter int          ERR_W       = 16
) (
  input logic                clk,
  input logic                rst,
  mult_eval_engine_if.slave  io_bus
);

  localparam int               P_W      = 2 * WIDTH;
  // Accumulate one bit wider than either operand so the saturation test sees the carry
  localparam int               SUM_W    = ((ERR_W > P_W) ? ERR_W : P_W) + 1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [15:0]      LAST_VEC = 16'(NUM_VECTORS - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_dut_a;
  logic [WIDTH-1:0]   r_dut_b;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_vec_count;
  logic [ERR_W-1:0]   r_err_count;
  logic [ERR_W-1:0]   r_abs_err_sum;
  logic [P_W-1:0]     r_max_abs_err;

  logic               w_lfsr_load;
  logic               w_lfsr_adv;
  logic [15:0]        w_load_val;
  logic [15:0]        w_lfsr_q;
  logic               w_unused_lfsr;
  logic [P_W-1:0]     w_ref;
  logic [P_W-1:0]     w_err;
  logic [SUM_W-1:0]   w_sum;
  logic [ERR_W-1:0]   w_abs_err_sum_nxt;
  logic [ERR_W-1:0]   w_err_count_nxt;

  // The LFSR is reseeded exactly when a start is accepted and steps once per scored vector
  assign w_lfsr_load = (r_state == ST_IDLE) && io_bus.start;
  assign w_lfsr_adv  = (r_state == ST_SAMPLE);
  assign w_load_val  = (io_bus.seed == 16'd0) ? LFSR_SEED : io_bus.seed;

  lfsr16 #(
    .SEED     (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_lfsr_load),
    .load_val (w_load_val),
    .adv      (w_lfsr_adv),
    .q        (w_lfsr_q)
  );

  // Only the low 2*WIDTH LFSR bits feed operands; the rest are deliberately dropped
  assign w_unused_lfsr = ^(w_lfsr_q >> P_W);

  // Exact product, absolute difference and saturating next values of the accumulators
  always_comb begin
    w_ref             = P_W'(r_dut_a) * P_W'(r_dut_b);
    w_err             = (io_bus.dut_p >= w_ref) ? (io_bus.dut_p - w_ref) : (w_ref - io_bus.dut_p);
    w_sum             = SUM_W'(r_abs_err_sum) + SUM_W'(w_err);
    w_abs_err_sum_nxt = (w_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : w_sum[ERR_W-1:0];
    w_err_count_nxt   = r_err_count;
    if ((w_err != '0) && (r_err_count != ERR_MAX)) begin
      w_err_count_nxt = r_err_count + ERR_W'(1);
    end
  end

  // Run sequencer: clear on start, drive a vector, score it, repeat, then pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_dut_a       <= '0;
      r_dut_b       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_vec_count   <= '0;
      r_err_count   <= '0;
      r_abs_err_sum <= '0;
      r_max_abs_err <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start) begin
            r_vec_count   <= '0;
            r_err_count   <= '0;
            r_abs_err_sum <= '0;
            r_max_abs_err <= '0;
            r_busy        <= 1'b1;
            r_state       <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_dut_a <= w_lfsr_q[WIDTH-1:0];
          r_dut_b <= w_lfsr_q[P_W-1:WIDTH];
          r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_err_count   <= w_err_count_nxt;
          r_abs_err_sum <= w_abs_err_sum_nxt;
          if (w_err > r_max_abs_err) begin
            r_max_abs_err <= w_err;
          end
          r_vec_count <= r_vec_count + 16'd1;
          if (r_vec_count == LAST_VEC) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.dut_a       = r_dut_a;
  assign io_bus.dut_b       = r_dut_b;
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.vec_count   = r_vec_count;
  assign io_bus.err_count   = r_err_count;
  assign io_bus.abs_err_sum = r_abs_err_sum;
  assign io_bus.max_abs_err = r_max_abs_err;

endmodule
